fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage sitting directly upstream of the program ROM. Owns the program
//  counter, drives the ROM address, captures the returned 16-bit word and presents decoded-ready
//  instructions (with their PC) to the decode stage. Handles stall, branch redirect/flush and
//  optional assembly of AVR two-word instructions (LDS/STS/JMP/CALL).
// PARAMETERS
//  DATA_WIDTH    16   instruction word width; must match the ROM
//  ADDR_WIDTH    8    PC / ROM address width
//  RESET_VECTOR  0    PC value loaded on reset
// PORTS
//  clk            in   1           system clock; all state changes on posedge
//  rst_n          in   1           asynchronous, active-low reset
//  rom_addr       out  ADDR_WIDTH  address to ROM; equals the pc register
//  rom_data       in   DATA_WIDTH  ROM word for rom_addr, stable before the next posedge
//  stall          in   1           hold pc and all outputs this cycle
//  branch_en      in   1           redirect fetch to branch_target this cycle
//  branch_target  in   ADDR_WIDTH  absolute redirect address
//  instr          out  DATA_WIDTH  instruction word (first word)
//  instr_op       out  DATA_WIDTH  second word of two-word instruction, else 0
//  instr_pc       out  ADDR_WIDTH  address of instr's first word
//  instr_valid    out  1           instr/instr_op/instr_pc valid this cycle
// BEHAVIOUR
//  - Reset (async, rst_n=0): pc=RESET_VECTOR, state=S_FETCH, instr=0, instr_op=0,
//    instr_pc=0, instr_valid=0. Reset mid-operation discards any half-fetched two-word instr.
//  - ROM contract: address changes at posedge; word is captured at the following posedge (1-cycle latency).
//  - Priority per posedge: branch_en > stall > normal fetch.
//  - branch_en=1: pc<=branch_target, state<=S_FETCH, instr_valid<=0 (word in flight discarded);
//    the word at branch_target is captured at the next posedge. Applies even while stall=1.
//  - stall=1 (no branch): pc, state and all outputs hold; rom_data ignored.
//  - S_FETCH, no stall: pc<=pc+1; if word is one-word: instr<=rom_data, instr_op<=0,
//    instr_pc<=pc, instr_valid<=1. If two-word (FETCH_TWO_WORD_EN only): latch word and pc
//    internally, instr_valid<=0, state<=S_OPND.
//  - S_OPND, no stall: instr<=latched word, instr_op<=rom_data, instr_pc<=latched pc,
//    instr_valid<=1, pc<=pc+1, state<=S_FETCH.
//  - PC arithmetic modulo 2^ADDR_WIDTH: pc=all-ones wraps to 0; a two-word instr straddling the
//    wrap takes its operand from address 0.
//  - Two-word detect: (w[15:10]==6'b100100 && w[3:0]==4'b0000) /*LDS,STS*/ ||
//    (w[15:9]==7'b1001010 && w[3:2]==2'b11) /*JMP,CALL*/.
// CONFIGURATION
//  FETCH_TWO_WORD_EN defined: S_OPND path active as above.
//  Not defined: every word treated as one-word; S_OPND unreachable/omitted; instr_op tied to 0.
// STRUCTURE
//  Shared package/header: state encodings (S_FETCH, S_OPND), two-word opcode masks/values.
//  One sub-module: two_word_detect (combinational, DATA_WIDTH word in, is_two_word out).
// TESTING
//  1 Reset with ROM 0:E0C3,1:B9C6,2:B116: release -> instr_valid rises, instr/instr_pc
//    sequence E0C3/0, B9C6/1, B116/2 on consecutive cycles.
//  2 stall=1 for 3 cycles after pc=1: rom_addr fixed at 1, outputs hold, sequence resumes unchanged.
//  3 branch_en=1, target=0x10 at pc=3: next cycle instr_valid=0, then instr=word@0x10, instr_pc=0x10.
//  4 With _EN: ROM 0:940C (JMP),1:0020,2:E0C3 -> one valid instr 940C/op 0020/pc 0, then E0C3/pc 2;
//    without _EN: three separate one-word instrs, instr_op=0.
//  5 pc=0xFF holds 9200 (STS), 0x00 holds 0x0060 -> instr_pc=0xFF, instr_op=0060, pc wraps to 1.
//  6 rst_n pulsed low while in S_OPND, and branch_en with stall both high -> reset values
//    immediately; branch taken, stall ignored.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_unit_pkg                                                           |
// | Shared state encodings and AVR two-word opcode masks for the fetch unit. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package fetch_unit_pkg;

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_OPND  = 1'b1
  } state_e;

  // LDS/STS: 1001_00xx_xxxx_0000
  localparam logic [15:0] LDS_STS_MASK  = 16'hFC0F;
  localparam logic [15:0] LDS_STS_VAL   = 16'h9000;
  // JMP/CALL: 1001_010x_xxxx_11xx
  localparam logic [15:0] JMP_CALL_MASK = 16'hFE0C;
  localparam logic [15:0] JMP_CALL_VAL  = 16'h940C;

  function automatic logic is_two_word_op(input logic [15:0] w);
    return ((w & LDS_STS_MASK) == LDS_STS_VAL) || ((w & JMP_CALL_MASK) == JMP_CALL_VAL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_two_word_detect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_unit_two_word_detect                                               |
// | Combinational flag for AVR words that carry a second operand word.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fetch_unit_two_word_detect
  import fetch_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] word,
  output logic                  is_two_word
);

  always_comb begin
    is_two_word = is_two_word_op(word[15:0]);
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_unit                                                               |
// | Instruction fetch stage: owns the PC, drives ROM address, presents       |
// | instructions with their PC. Two-word assembly under FETCH_TWO_WORD_EN.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 8,
  parameter int RESET_VECTOR = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  input  logic                  stall,
  input  logic                  branch_en,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_op,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid
);

  localparam logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(RESET_VECTOR);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  instr_valid_q, instr_valid_d;

`ifdef FETCH_TWO_WORD_EN
  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] instr_op_q, instr_op_d;
  logic [DATA_WIDTH-1:0] hold_word_q, hold_word_d;
  logic [ADDR_WIDTH-1:0] hold_pc_q, hold_pc_d;
  logic                  is_two_word;

  fetch_unit_two_word_detect #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_two_word_detect (
    .word        (rom_data),
    .is_two_word (is_two_word)
  );
`endif

  always_comb begin
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
`ifdef FETCH_TWO_WORD_EN
    state_d       = state_q;
    instr_op_d    = instr_op_q;
    hold_word_d   = hold_word_q;
    hold_pc_d     = hold_pc_q;
`endif
    if (branch_en) begin
      // The word currently on rom_data belongs to the abandoned path.
      pc_d          = branch_target;
      instr_valid_d = 1'b0;
`ifdef FETCH_TWO_WORD_EN
      state_d       = S_FETCH;
`endif
    end else if (!stall) begin
      pc_d = pc_q + ADDR_WIDTH'(1);
`ifdef FETCH_TWO_WORD_EN
      if (state_q == S_OPND) begin
        instr_d       = hold_word_q;
        instr_op_d    = rom_data;
        instr_pc_d    = hold_pc_q;
        instr_valid_d = 1'b1;
        state_d       = S_FETCH;
      end else if (is_two_word) begin
        hold_word_d   = rom_data;
        hold_pc_d     = pc_q;
        instr_valid_d = 1'b0;
        state_d       = S_OPND;
      end else begin
        instr_d       = rom_data;
        instr_op_d    = '0;
        instr_pc_d    = pc_q;
        instr_valid_d = 1'b1;
      end
`else
      instr_d       = rom_data;
      instr_pc_d    = pc_q;
      instr_valid_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
`ifdef FETCH_TWO_WORD_EN
      state_q       <= S_FETCH;
      instr_op_q    <= '0;
      hold_word_q   <= '0;
      hold_pc_q     <= '0;
`endif
    end else begin
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
`ifdef FETCH_TWO_WORD_EN
      state_q       <= state_d;
      instr_op_q    <= instr_op_d;
      hold_word_q   <= hold_word_d;
      hold_pc_q     <= hold_pc_d;
`endif
    end
  end

  assign rom_addr    = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
`ifdef FETCH_TWO_WORD_EN
  assign instr_op    = instr_op_q;
`else
  assign instr_op    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_unit                                                            |
// | Directed scoreboard bench for fetch_unit (both FETCH_TWO_WORD_EN builds). |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        stall;
  logic        branch_en;
  logic [7:0]  branch_target;
  logic [15:0] instr;
  logic [15:0] instr_op;
  logic [7:0]  instr_pc;
  logic        instr_valid;

  logic [15:0] rom [256];

  typedef struct {
    logic [15:0] w;
    logic [15:0] op;
    logic [7:0]  pc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .stall         (stall),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .instr         (instr),
    .instr_op      (instr_op),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w, input logic [15:0] op, input logic [7:0] pc);
    exp_t e;
    e.w = w; e.op = op; e.pc = pc;
    q.push_back(e);
  endtask

  // One cycle in which the DUT must present the next scoreboard entry.
  task automatic cycle_new(input string tag);
    exp_t e;
    tick();
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb: observed=empty scoreboard expected=entry", tag);
    end else begin
      e = q.pop_front();
      check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
      check({tag, "_instr"}, {16'd0, instr}, {16'd0, e.w});
      check({tag, "_op"},    {16'd0, instr_op}, {16'd0, e.op});
      check({tag, "_pc"},    {24'd0, instr_pc}, {24'd0, e.pc});
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[8'h00] = 16'hE0C3; rom[8'h01] = 16'hB9C6; rom[8'h02] = 16'hB116;
    rom[8'h10] = 16'h1234; rom[8'h11] = 16'h5678;
    rom[8'h20] = 16'h940C; rom[8'h21] = 16'h0020; rom[8'h22] = 16'hE0C3;
    rom[8'hFF] = 16'h9200;

    rst_n = 1'b0; stall = 1'b0; branch_en = 1'b0; branch_target = 8'h00;
    tick(); tick();
    check("rst_addr",  {24'd0, rom_addr}, 32'h00);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", {16'd0, instr}, 32'h0);
    check("rst_op",    {16'd0, instr_op}, 32'h0);
    check("rst_pc",    {24'd0, instr_pc}, 32'h0);

    // Plain sequential fetch, then a 3-cycle stall at pc=1
    rst_n = 1'b1;
    push(16'hE0C3, 16'h0, 8'h00);
    cycle_new("seq0");
    check("pre_stall_addr", {24'd0, rom_addr}, 32'h01);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_addr",  {24'd0, rom_addr}, 32'h01);
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
      check("stall_instr", {16'd0, instr}, 32'hE0C3);
      check("stall_pc",    {24'd0, instr_pc}, 32'h00);
    end
    stall = 1'b0;
    push(16'hB9C6, 16'h0, 8'h01);
    push(16'hB116, 16'h0, 8'h02);
    cycle_new("seq1");
    cycle_new("seq2");

    // Branch at pc=3 to 0x10
    check("pre_br_addr", {24'd0, rom_addr}, 32'h03);
    branch_en = 1'b1; branch_target = 8'h10;
    tick();
    branch_en = 1'b0;
    check("br_valid", {31'd0, instr_valid}, 32'd0);
    check("br_addr",  {24'd0, rom_addr}, 32'h10);
    push(16'h1234, 16'h0, 8'h10);
    push(16'h5678, 16'h0, 8'h11);
    cycle_new("br0");
    cycle_new("br1");

    // Branch with stall also high to the JMP at 0x20
    branch_en = 1'b1; stall = 1'b1; branch_target = 8'h20;
    tick();
    branch_en = 1'b0; stall = 1'b0;
    check("brst_valid", {31'd0, instr_valid}, 32'd0);
    check("brst_addr",  {24'd0, rom_addr}, 32'h20);
`ifdef FETCH_TWO_WORD_EN
    tick();
    check("jmp_half_valid", {31'd0, instr_valid}, 32'd0);
    check("jmp_half_addr",  {24'd0, rom_addr}, 32'h21);
    push(16'h940C, 16'h0020, 8'h20);
    push(16'hE0C3, 16'h0000, 8'h22);
    cycle_new("jmp");
    cycle_new("jmp_next");
`else
    push(16'h940C, 16'h0, 8'h20);
    push(16'h0020, 16'h0, 8'h21);
    push(16'hE0C3, 16'h0, 8'h22);
    cycle_new("w0");
    cycle_new("w1");
    cycle_new("w2");
`endif

    // STS straddling the PC wrap
    rom[8'h00] = 16'h0060;
    branch_en = 1'b1; branch_target = 8'hFF;
    tick();
    branch_en = 1'b0;
`ifdef FETCH_TWO_WORD_EN
    tick();
    check("wrap_half_valid", {31'd0, instr_valid}, 32'd0);
    check("wrap_half_addr",  {24'd0, rom_addr}, 32'h00);
    push(16'h9200, 16'h0060, 8'hFF);
    cycle_new("wrap");
`else
    push(16'h9200, 16'h0, 8'hFF);
    push(16'h0060, 16'h0, 8'h00);
    cycle_new("wrap0");
    cycle_new("wrap1");
`endif
    check("wrap_addr", {24'd0, rom_addr}, 32'h01);

    // Asynchronous reset while half-way through the JMP at 0x20
    branch_en = 1'b1; branch_target = 8'h20;
    tick();
    branch_en = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, instr_valid}, 32'd0);
    check("arst_instr", {16'd0, instr}, 32'h0);
    check("arst_op",    {16'd0, instr_op}, 32'h0);
    check("arst_pc",    {24'd0, instr_pc}, 32'h0);
    check("arst_addr",  {24'd0, rom_addr}, 32'h00);
    tick();
    rst_n = 1'b1;
    push(16'h0060, 16'h0, 8'h00);
    push(16'hB9C6, 16'h0, 8'h01);
    cycle_new("post_rst0");
    cycle_new("post_rst1");

    checks++;
    if (q.size() != 0) begin
      errors++;
      $error("FAIL sb_drain: observed=%0d entries expected=0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
